// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pool over a raster-ordered IN_W x IN_W stream.
// Horizontal pairs are reduced in a single holding register. Even-row pair
// maxima are parked in a half-width line buffer, and each odd-row pair is
// combined with its parked partner to emit one pooled element.
module max_pool_2x2 #(
    parameter int IN_W   = 30,
    parameter int DATA_W = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_signal,
    input  logic                     conv_valid,
    input  logic signed [DATA_W-1:0] conv_in,
    output logic                     pool_valid,
    output logic signed [DATA_W-1:0] pool_out,
    output logic                     pool_last,
    output logic                     frame_done
);

    localparam int              CW   = $clog2(IN_W);
    localparam int              HALF = IN_W / 2;
    localparam logic [CW-1:0]   LAST = CW'(IN_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    r_state, w_next;
    logic [CW-1:0]             r_col, r_row;
    logic signed [DATA_W-1:0]  r_pair;
    logic signed [DATA_W-1:0]  r_lbuf [HALF];
    logic signed [DATA_W-1:0]  r_pool_out;
    logic                      r_pool_valid, r_pool_last;

    logic                      w_accept, w_col_last, w_row_last, w_frame_end, w_emit;
    logic [CW-2:0]             w_lidx;
    logic signed [DATA_W-1:0]  w_pmax, w_lbuf_rd, w_omax;

    // An element in the start_signal cycle belongs to no frame and is dropped.
    assign w_accept    = conv_valid && (r_state == RUN) && !start_signal;
    assign w_col_last  = (r_col == LAST);
    assign w_row_last  = (r_row == LAST);
    assign w_frame_end = w_accept && w_col_last && w_row_last;
    assign w_emit      = w_accept && r_row[0] && r_col[0];
    assign w_lidx      = r_col[CW-1:1];
    assign w_lbuf_rd   = r_lbuf[w_lidx];
    assign w_pmax      = (r_pair > conv_in) ? r_pair : conv_in;
    assign w_omax      = (w_pmax > w_lbuf_rd) ? w_pmax : w_lbuf_rd;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state: start restarts from anywhere; the last accepted element ends the frame.
    always_comb begin
        w_next = r_state;
        if (start_signal)
            w_next = RUN;
        else if (r_state == RUN && w_frame_end)
            w_next = DONE;
    end

    // Column/row position of the next element to be accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (start_signal) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Hold the even-column element until its odd-column partner arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pair <= '0;
        else if (start_signal)
            r_pair <= '0;
        else if (w_accept && !r_col[0])
            r_pair <= conv_in;
    end

    // Park even-row pair maxima; every entry is rewritten before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0] && r_col[0])
            r_lbuf[w_lidx] <= w_pmax;
    end

    // Register the pooled result one cycle after its closing element; data holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pool_valid <= 1'b0;
            r_pool_last  <= 1'b0;
            r_pool_out   <= '0;
        end else begin
            r_pool_valid <= w_emit;
            r_pool_last  <= w_emit && w_frame_end;
            if (w_emit)
                r_pool_out <= w_omax;
        end
    end

    assign pool_valid = r_pool_valid;
    assign pool_last  = r_pool_last;
    assign pool_out   = r_pool_out;
    // DONE is entered on the same edge that raises pool_last.
    assign frame_done = (r_state == DONE);

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: a frame-array reference model pushes expected
// pooled values into a scoreboard while a negedge monitor pops and compares.
module tb_max_pool_2x2;

    localparam int W   = 30;
    localparam int DW  = 22;
    localparam int NIN = W * W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_signal;
    logic                 conv_valid;
    logic signed [DW-1:0] conv_in;
    logic                 pool_valid;
    logic signed [DW-1:0] pool_out;
    logic                 pool_last;
    logic                 frame_done;

    max_pool_2x2 #(.IN_W(W), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .conv_valid   (conv_valid),
        .conv_in      (conv_in),
        .pool_valid   (pool_valid),
        .pool_out     (pool_out),
        .pool_last    (pool_last),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] val;
        bit                   last;
        int                   cyc;
    } exp_t;

    exp_t                 sb[$];
    logic signed [DW-1:0] fr [W][W];
    int                   total = 0;
    int                   bad   = 0;
    int                   cyc   = 0;
    bit                   in_frame = 0;
    int                   idx = 0;
    logic signed [DW-1:0] hold = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] gen(input int mode, input int i);
        case (mode)
            0:       return DW'(i);
            1:       return DW'(-i - 1);
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // One driven cycle; the model decides from frame position alone what the DUT must emit.
    task automatic drive_cycle(input bit st, input bit v, input logic signed [DW-1:0] d);
        int r, c;
        exp_t e;
        @(posedge clk);
        #1;
        start_signal = st;
        conv_valid   = v;
        conv_in      = d;
        if (st) begin
            in_frame = 1;
            idx      = 0;
        end else if (v && in_frame && idx < NIN) begin
            r = idx / W;
            c = idx % W;
            fr[r][c] = d;
            if (r % 2 == 1 && c % 2 == 1) begin
                e.val  = smax(smax(fr[r-1][c-1], fr[r-1][c]), smax(fr[r][c-1], fr[r][c]));
                e.last = (idx == NIN - 1);
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            idx++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, '0);
    endtask

    task automatic do_start();
        drive_cycle(1, 1, gen(2, 0));
        drive_cycle(0, 0, '0);
        @(negedge clk);
        chk("frame_done_after_start", frame_done, 0);
        chk("pool_valid_after_start", pool_valid, 0);
    endtask

    task automatic run(input int mode, input int n, input bit gaps);
        int  sent  = 0;
        int  guard = 0;
        bit  tog   = 1;
        bit  v;
        while (sent < n && guard < 20000) begin
            v   = gaps ? (tog && ($urandom_range(0, 3) != 0)) : 1'b1;
            tog = ~tog;
            drive_cycle(0, v, gen(mode, sent % NIN));
            if (v) sent++;
            guard++;
        end
        chk("run_completed", sent, n);
    endtask

    // Monitor: every pool_valid must match the head of the scoreboard in value, flags and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold = '0;
        end else if (pool_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_pool_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pool_out", pool_out, e.val);
                chk("pool_last", pool_last, e.last);
                chk("latency_cycle", cyc, e.cyc);
                chk("frame_done_with_last", frame_done, e.last);
                hold = e.val;
            end
        end else begin
            chk("pool_last_idle", pool_last, 0);
            chk("pool_out_hold", pool_out, hold);
        end
    end

    initial begin
        rst          = 1'b0;
        start_signal = 1'b0;
        conv_valid   = 1'b0;
        conv_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pool_valid", pool_valid, 0);
        chk("rst_pool_out", pool_out, 0);
        chk("rst_pool_last", pool_last, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Input before any start is ignored.
        run(0, 40, 0);
        idle(2);

        // Ramp frame, back to back.
        do_start();
        run(0, NIN, 0);
        idle(3);
        @(negedge clk);
        chk("frame_done_ramp", frame_done, 1);

        // All-negative frame.
        do_start();
        run(1, NIN, 0);
        idle(3);
        @(negedge clk);
        chk("frame_done_neg", frame_done, 1);

        // Ramp with toggling valid and random stalls.
        do_start();
        run(0, NIN, 1);
        idle(3);

        // Partial frame abandoned by a restart.
        do_start();
        run(0, 450, 0);
        do_start();
        run(0, NIN, 0);
        idle(3);

        // Overrun: elements past the frame are ignored.
        do_start();
        run(0, 950, 0);
        idle(3);
        @(negedge clk);
        chk("frame_done_overrun", frame_done, 1);

        // Random data with gaps.
        do_start();
        run(2, NIN, 1);
        idle(3);

        // Asynchronous reset mid-frame.
        do_start();
        run(2, 400, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        in_frame = 0;
        #1;
        chk("async_rst_pool_valid", pool_valid, 0);
        chk("async_rst_pool_out", pool_out, 0);
        chk("async_rst_pool_last", pool_last, 0);
        chk("async_rst_frame_done", frame_done, 0);
        conv_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run(0, NIN, 0);
        idle(3);
        @(negedge clk);
        chk("post_rst_frame_done", frame_done, 0);

        idle(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
